// File: rtl/opram_pkg.sv
// Shared constants and payload types for the op RAM arbiter slice.
package opram_pkg;

    localparam int unsigned AW             = 8;
    localparam int unsigned DW             = 8;
    localparam int unsigned RAM_DEPTH      = 1 << AW;
    localparam int unsigned READ_LAT_DEF   = 1;
    localparam int unsigned STARVE_LIM_DEF = 4;

    // Winner of the single RAM slot in a cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WR   = 2'd1,
        GNT_RD   = 2'd2
    } gnt_e;

    // Pin-level command presented to the op RAM.
    typedef struct packed {
        logic          wre;
        logic [AW-1:0] ad;
        logic [DW-1:0] din;
    } ram_cmd_t;

endpackage

// File: rtl/opram_arbiter_if.sv
// Requester-side bus of the op RAM arbiter: loader write port and fetch read port.
interface opram_arbiter_if;
    import opram_pkg::*;

    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_req;
    logic          rd_gnt;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [DW-1:0] rd_data;

    modport master (
        output wr_valid, wr_addr, wr_data, rd_req, rd_addr,
        input  wr_ready, rd_gnt, rd_valid, rd_data
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_req, rd_addr,
        output wr_ready, rd_gnt, rd_valid, rd_data
    );

endinterface

// File: rtl/opram_rd_pipe.sv
// Tracks granted reads through the RAM latency and returns the op on the matching cycle.
module opram_rd_pipe
    import opram_pkg::*;
#(
    parameter int unsigned READ_LAT = READ_LAT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue,
    input  logic [DW-1:0] ram_dout,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          in_flight
);

    logic [READ_LAT-1:0] pipe_q;
    logic [DW-1:0]       hold_q;

    // One valid bit per cycle of RAM latency.
    generate
        if (READ_LAT == 1) begin : g_lat1
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q <= issue;
                end
            end
        end else begin : g_latn
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q <= {pipe_q[READ_LAT-2:0], issue};
                end
            end
        end
    endgenerate

    // Keeps the last returned op visible between returns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
        end else if (rd_valid) begin
            hold_q <= ram_dout;
        end
    end

    assign rd_valid  = pipe_q[READ_LAT-1];
    assign rd_data   = rd_valid ? ram_dout : hold_q;
    assign in_flight = |pipe_q;

endmodule

// File: rtl/opram_arbiter.sv
// Op RAM arbiter: one RAM access per cycle between the loader (write) and fetch (read).
// Optional write protection below a base address: define OPRAM_ARB_WPROT_EN.
module opram_arbiter
    import opram_pkg::*;
#(
    parameter int unsigned READ_LAT   = READ_LAT_DEF,
    parameter int unsigned STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic            clk,
    input  logic            rst,
    opram_arbiter_if.slave  bus,
    output logic            ram_ce,
    output logic            ram_oce,
    output logic            ram_wre,
    output logic [AW-1:0]   ram_ad,
    output logic [DW-1:0]   ram_din,
    input  logic [DW-1:0]   ram_dout,
    output logic            busy
`ifdef OPRAM_ARB_WPROT_EN
    ,
    input  logic            wp_en,
    input  logic [AW-1:0]   wp_base,
    output logic            wp_err
`endif
);

    localparam int unsigned SW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

    gnt_e          gnt;
    ram_cmd_t      cmd;
    logic          starved;
    logic          wr_hazard;
    logic          wr_grant;
    logic          rd_grant;
    logic          in_flight;
    logic          wp_block;
    logic [SW-1:0] starve_q;
    logic [AW-1:0] ad_q;
    logic [DW-1:0] din_q;

    assign starved = (starve_q >= SW'(STARVE_LIM));

    // A pipelined RAM output register needs oce high until outstanding reads are delivered.
    assign wr_hazard = (READ_LAT >= 2) && in_flight;

`ifdef OPRAM_ARB_WPROT_EN
    assign wp_block = wp_en && (bus.wr_addr < wp_base);
`else
    assign wp_block = 1'b0;
`endif

    // Read has priority unless the write is starved or the fetch is idle.
    always_comb begin
        gnt = GNT_NONE;
        if (!rst) begin
            if (bus.wr_valid && (starved || !bus.rd_req)) begin
                if (!wr_hazard) begin
                    gnt = GNT_WR;
                end
            end else if (bus.rd_req) begin
                gnt = GNT_RD;
            end
        end
    end

    assign wr_grant    = (gnt == GNT_WR);
    assign rd_grant    = (gnt == GNT_RD);
    assign bus.wr_ready = wr_grant;
    assign bus.rd_gnt   = rd_grant;

    // RAM pins follow the grant in the same cycle; address and data hold when idle.
    always_comb begin
        cmd = '{wre: 1'b0, ad: ad_q, din: din_q};
        unique case (gnt)
            GNT_WR: begin
                cmd.wre = !wp_block;
                cmd.ad  = bus.wr_addr;
                cmd.din = bus.wr_data;
            end
            GNT_RD: begin
                cmd.ad = bus.rd_addr;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ad_q  <= '0;
            din_q <= '0;
        end else begin
            ad_q  <= cmd.ad;
            din_q <= cmd.din;
        end
    end

    // Counts refused write cycles, saturating at the starvation limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else if (bus.wr_valid && !wr_grant) begin
            if (!starved) begin
                starve_q <= starve_q + SW'(1);
            end
        end else begin
            starve_q <= '0;
        end
    end

`ifdef OPRAM_ARB_WPROT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_err <= 1'b0;
        end else begin
            wp_err <= wr_grant && wp_block;
        end
    end
`endif

    opram_rd_pipe #(
        .READ_LAT (READ_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .issue     (rd_grant),
        .ram_dout  (ram_dout),
        .rd_valid  (bus.rd_valid),
        .rd_data   (bus.rd_data),
        .in_flight (in_flight)
    );

    assign ram_ce  = 1'b1;
    assign ram_wre = cmd.wre;
    assign ram_oce = !cmd.wre;
    assign ram_ad  = cmd.ad;
    assign ram_din = cmd.din;
    assign busy    = !rst && (in_flight || bus.wr_valid || bus.rd_req);

endmodule

// File: tb/tb_opram_arbiter.sv
// Bench for opram_arbiter: RAM model, arbitration reference model and read-return scoreboard.
// Write-protection checks are compiled in with OPRAM_ARB_WPROT_EN.
module tb_opram_arbiter;
    import opram_pkg::*;

    parameter int unsigned LAT = READ_LAT_DEF;
    parameter int unsigned LIM = STARVE_LIM_DEF;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          ram_ce;
    logic          ram_oce;
    logic          ram_wre;
    logic [AW-1:0] ram_ad;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          busy;
`ifdef OPRAM_ARB_WPROT_EN
    logic          wp_en;
    logic [AW-1:0] wp_base;
    logic          wp_err;
    logic          wperr_pend = 1'b0;
`endif

    opram_arbiter_if bus ();

    opram_arbiter #(
        .READ_LAT   (LAT),
        .STARVE_LIM (LIM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .ram_ce   (ram_ce),
        .ram_oce  (ram_oce),
        .ram_wre  (ram_wre),
        .ram_ad   (ram_ad),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .busy     (busy)
`ifdef OPRAM_ARB_WPROT_EN
        ,
        .wp_en    (wp_en),
        .wp_base  (wp_base),
        .wp_err   (wp_err)
`endif
    );

    int            n_chk  = 0;
    int            n_pass = 0;
    int            cyc    = 0;
    int            sc     = 0;
    int            last_rd = -1000;
    logic [AW-1:0] last_ad = '0;
    logic          m_wacc = 1'b0;
    logic          m_rgnt = 1'b0;
    logic [DW-1:0] ref_mem [RAM_DEPTH];
    logic [DW-1:0] mem     [RAM_DEPTH];
    logic [DW-1:0] core_q = '0;
    logic [DW-1:0] oreg_q = '0;
    exp_t          exp_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Single-port RAM: bypass output for latency 1, oce-gated output register for latency 2.
    initial begin
        for (int i = 0; i < int'(RAM_DEPTH); i++) mem[i] = 8'(i * 37 + 11);
        forever begin
            @(posedge clk);
            if (ram_ce) begin
                if (ram_oce) oreg_q <= core_q;
                if (ram_wre) mem[ram_ad] = ram_din;
                else core_q <= mem[ram_ad];
            end
        end
    end
    assign ram_dout = (LAT == 1) ? core_q : oreg_q;

    // Reference model: arbitration rules, RAM pin expectations, read-return expectations.
    initial begin
        logic starved, win, ew, er, blocked, exp_wre, inflight;
        for (int i = 0; i < int'(RAM_DEPTH); i++) ref_mem[i] = 8'(i * 37 + 11);
        forever begin
            @(negedge clk);
            if (rst) begin
                sc = 0;
                last_rd = -1000;
                last_ad = '0;
                exp_q.delete();
                m_wacc = 1'b0;
                m_rgnt = 1'b0;
`ifdef OPRAM_ARB_WPROT_EN
                wperr_pend = 1'b0;
`endif
            end else begin
                inflight = (cyc - last_rd) <= int'(LAT);
                starved  = sc >= int'(LIM);
                win      = bus.wr_valid && (starved || !bus.rd_req);
                ew       = win && !(LAT >= 2 && inflight);
                er       = bus.rd_req && !win;
                blocked  = 1'b0;
`ifdef OPRAM_ARB_WPROT_EN
                blocked = wp_en && (bus.wr_addr < wp_base);
                chk("wp_err", 32'(wp_err), 32'(wperr_pend));
                wperr_pend = ew && blocked;
`endif
                exp_wre = ew && !blocked;
                chk("wr_ready", 32'(bus.wr_ready), 32'(ew));
                chk("rd_gnt", 32'(bus.rd_gnt), 32'(er));
                chk("ram_ce", 32'(ram_ce), 32'd1);
                chk("ram_wre", 32'(ram_wre), 32'(exp_wre));
                chk("ram_oce", 32'(ram_oce), 32'(!exp_wre));
                chk("busy", 32'(busy), 32'(inflight || bus.wr_valid || bus.rd_req));
                if (ew) begin
                    chk("ram_ad_wr", 32'(ram_ad), 32'(bus.wr_addr));
                    chk("ram_din_wr", 32'(ram_din), 32'(bus.wr_data));
                    if (!blocked) ref_mem[bus.wr_addr] = bus.wr_data;
                    last_ad = bus.wr_addr;
                end else if (er) begin
                    chk("ram_ad_rd", 32'(ram_ad), 32'(bus.rd_addr));
                    exp_q.push_back('{due: cyc + int'(LAT), data: ref_mem[bus.rd_addr]});
                    last_rd = cyc;
                    last_ad = bus.rd_addr;
                end else begin
                    chk("ram_ad_idle", 32'(ram_ad), 32'(last_ad));
                end
                if (bus.wr_valid && !ew) sc = (sc + 1 > int'(LIM)) ? int'(LIM) : sc + 1;
                else sc = 0;
                m_wacc = ew;
                m_rgnt = er;
            end
        end
    end

    // Scoreboard monitor: every rd_valid must match the oldest expected return, on time.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (bus.rd_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("rd_valid_unexpected", 32'(bus.rd_valid), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rd_data", 32'(bus.rd_data), 32'(e.data));
                        chk("rd_latency", 32'(cyc), 32'(e.due));
                    end
                end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                    chk("rd_valid_missing", 32'(bus.rd_valid), 32'd1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_wr_ready"}, 32'(bus.wr_ready), 32'd0);
        chk({tag, "_rd_gnt"}, 32'(bus.rd_gnt), 32'd0);
        chk({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'd0);
        chk({tag, "_rd_data"}, 32'(bus.rd_data), 32'd0);
        chk({tag, "_ram_wre"}, 32'(ram_wre), 32'd0);
        chk({tag, "_ram_ad"}, 32'(ram_ad), 32'd0);
        chk({tag, "_ram_din"}, 32'(ram_din), 32'd0);
        chk({tag, "_ram_ce"}, 32'(ram_ce), 32'd1);
        chk({tag, "_ram_oce"}, 32'(ram_oce), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
`ifdef OPRAM_ARB_WPROT_EN
        chk({tag, "_wp_err"}, 32'(wp_err), 32'd0);
`endif
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic done;
        done = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        for (int k = 0; k < 64 && !done; k++) begin
            step();
            done = m_wacc;
        end
        bus.wr_valid = 1'b0;
        chk("write_accepted", 32'(done), 32'd1);
    endtask

    // Leaves rd_req asserted so consecutive calls issue back-to-back reads.
    task automatic do_read(input logic [AW-1:0] a);
        logic done;
        done = 1'b0;
        bus.rd_req  = 1'b1;
        bus.rd_addr = a;
        for (int k = 0; k < 64 && !done; k++) begin
            step();
            done = m_rgnt;
        end
        chk("read_granted", 32'(done), 32'd1);
    endtask

    task automatic idle(input int n);
        bus.wr_valid = 1'b0;
        bus.rd_req   = 1'b0;
        repeat (n) step();
    endtask

    // Loader holds its write until accepted; fetch requests freely every cycle.
    task automatic rand_phase(input int n);
        for (int k = 0; k < n; k++) begin
            if (!bus.wr_valid || m_wacc) begin
                bus.wr_valid = ($urandom_range(0, 99) < 40);
                bus.wr_addr  = AW'($urandom_range(0, 15));
                bus.wr_data  = DW'($urandom);
            end
            bus.rd_req  = ($urandom_range(0, 99) < 60);
            bus.rd_addr = AW'($urandom_range(0, 15));
`ifdef OPRAM_ARB_WPROT_EN
            wp_en   = ($urandom_range(0, 3) == 0);
            wp_base = AW'($urandom_range(0, 16));
`endif
            step();
        end
        idle(1);
    endtask

    initial begin
        int   refused;
        logic got;
        rst          = 1'b1;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rd_req   = 1'b0;
        bus.rd_addr  = '0;
`ifdef OPRAM_ARB_WPROT_EN
        wp_en   = 1'b0;
        wp_base = '0;
`endif
        repeat (2) step();
        chk_reset("rst0");
        rst = 1'b0;
        step();

        do_write(8'h10, 8'hA5);
        do_read(8'h10);
        idle(4);

        // Continuous fetch against a held write: write must win once starved.
        bus.rd_req   = 1'b1;
        bus.rd_addr  = 8'h03;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 8'h21;
        bus.wr_data  = 8'h5C;
        refused = 0;
        got     = 1'b0;
        for (int k = 0; k < 32 && !got; k++) begin
            step();
            if (m_wacc) got = 1'b1;
            else refused++;
        end
        chk("starve_refusals", 32'(refused), 32'((LAT >= 2) ? LIM + LAT : LIM));
        idle(4);

        for (int i = 0; i < 8; i++) do_write(AW'(i), DW'(8'hC0 + i));
        idle(2);
        for (int i = 0; i < 8; i++) do_read(AW'(i));
        idle(4);

`ifdef OPRAM_ARB_WPROT_EN
        wp_en   = 1'b1;
        wp_base = 8'h20;
        do_write(8'h1F, 8'h77);
        do_write(8'h20, 8'h88);
        wp_en = 1'b0;
        do_read(8'h1F);
        do_read(8'h20);
        idle(4);
`endif

        rand_phase(600);
        idle(4);

        // Reset with reads in flight and requests still asserted.
        for (int i = 0; i < 3; i++) do_read(AW'(8'h40 + i));
        bus.wr_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk_reset("rst_mid");
        step();
        step();
        bus.wr_valid = 1'b0;
        bus.rd_req   = 1'b0;
        rst = 1'b0;
        idle(6);

        rand_phase(300);
        idle(6);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
